// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state
// encoding, opcode/funct constants, aluop encodings, ALU operation codes
// and the internal control word the FSM produces each cycle.
package mips_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUCTL_W = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

  // Per-state control word before pcen/alucontrol are derived from it.
  typedef struct packed {
    logic              iord;
    logic              irwrite;
    logic              memwrite;
    logic              regwrite;
    logic              regdst;
    logic              memtoreg;
    logic              alusrca;
    logic              pcwrite;
    logic              branch;
    logic [SEL_W-1:0]  alusrcb;
    logic [SEL_W-1:0]  pcsrc;
    aluop_e            aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle.
//   op, funct, zero : instruction fields and ALU zero flag into the controller
//   iord .. pcen    : 1-bit datapath controls out of the controller
//   alusrcb, pcsrc  : 2-bit mux selects; alucontrol : 3-bit ALU operation
// master = controller side, slave = datapath side.
interface mc_controller_if;
  import mips_ctrl_pkg::*;

  logic [OP_W-1:0]     op;
  logic [FUNCT_W-1:0]  funct;
  logic                zero;
  logic                iord;
  logic                irwrite;
  logic                memwrite;
  logic                regwrite;
  logic                regdst;
  logic                memtoreg;
  logic                alusrca;
  logic                pcen;
  logic [SEL_W-1:0]    alusrcb;
  logic [SEL_W-1:0]    pcsrc;
  logic [ALUCTL_W-1:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
           pcen, alusrcb, pcsrc, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
           pcen, alusrcb, pcsrc, alucontrol
  );
endinterface

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's aluop (and funct for R-type) to an ALU code.
//   funct      : instr[5:0]
//   aluop      : add / sub / use-funct / reserved
//   alucontrol : ALU operation code (combinational)
module aludec
  import mips_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0]  funct,
  input  aluop_e              aluop,
  output logic [ALUCTL_W-1:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      ALUOP_ADD:  alucontrol = ALU_ADD;
      ALUOP_SUB:  alucontrol = ALU_SUB;
      ALUOP_RSVD: alucontrol = ALU_ADD;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller (Moore FSM + ALU decoder).
//   clk   : rising-edge clock
//   reset : synchronous active-high; holds FETCH and masks all writes
//   bus   : master side of mc_controller_if (op/funct/zero in, controls out)
// All outputs are combinational from state, op and funct.
module mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mc_controller_if.master  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                 state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Per-state control word; reset forces the FETCH word with writes masked.
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = 2'b01;
      end
      S_DECODE:  ctrl.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      S_MEMRD:   ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      S_ADDIWB:  ctrl.regwrite = 1'b1;
      S_JUMP: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (reset) begin
      ctrl         = '0;
      ctrl.alusrcb = 2'b01;
    end
  end

  aludec u_aludec (
    .funct      (bus.funct),
    .aluop      (ctrl.aluop),
    .alucontrol (bus.alucontrol)
  );

  assign bus.iord     = ctrl.iord;
  assign bus.irwrite  = ctrl.irwrite;
  assign bus.memwrite = ctrl.memwrite;
  assign bus.regwrite = ctrl.regwrite;
  assign bus.regdst   = ctrl.regdst;
  assign bus.memtoreg = ctrl.memtoreg;
  assign bus.alusrca  = ctrl.alusrca;
  assign bus.alusrcb  = ctrl.alusrcb;
  assign bus.pcsrc    = ctrl.pcsrc;
  // branch is only set in BRANCH, so zero matters only there.
  assign bus.pcen     = ctrl.pcwrite | (ctrl.branch & bus.zero);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed vector table, randomized instruction
// stream against a cycle-indexed instruction model, and a reset-abort case.
module tb_mc_controller;
  import mips_ctrl_pkg::*;

  typedef logic [14:0] word_t;  // {iord,irw,mw,rw,rd,m2r,asa,pcen,srcb,pcsrc,alu}

  localparam word_t W_RESET  = {8'b0000_0000, 2'b01, 2'b00, 3'b010};
  localparam word_t W_FETCH  = {8'b0100_0001, 2'b01, 2'b00, 3'b010};
  localparam word_t W_DECODE = {8'b0000_0000, 2'b11, 2'b00, 3'b010};
  localparam word_t W_MEMADR = {8'b0000_0010, 2'b10, 2'b00, 3'b010};
  localparam word_t W_MEMRD  = {8'b1000_0000, 2'b00, 2'b00, 3'b010};
  localparam word_t W_MEMWB  = {8'b0001_0100, 2'b00, 2'b00, 3'b010};
  localparam word_t W_MEMWR  = {8'b1010_0000, 2'b00, 2'b00, 3'b010};
  localparam word_t W_ALUWB  = {8'b0001_1000, 2'b00, 2'b00, 3'b010};
  localparam word_t W_ADDIEX = {8'b0000_0010, 2'b10, 2'b00, 3'b010};
  localparam word_t W_ADDIWB = {8'b0001_0000, 2'b00, 2'b00, 3'b010};
  localparam word_t W_JUMP   = {8'b0000_0001, 2'b00, 2'b10, 3'b010};
  localparam word_t W_BR_Z0  = {8'b0000_0010, 2'b00, 2'b01, 3'b110};
  localparam word_t W_BR_Z1  = {8'b0000_0011, 2'b00, 2'b01, 3'b110};

  function automatic word_t w_exec(input logic [2:0] alu);
    return {8'b0000_0010, 2'b00, 2'b00, alu};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    word_t       exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_controller_if bus ();
  mc_controller dut (.clk(clk), .reset(reset), .bus(bus));

  word_t act;
  assign act = {bus.iord, bus.irwrite, bus.memwrite, bus.regwrite, bus.regdst,
                bus.memtoreg, bus.alusrca, bus.pcen, bus.alusrcb, bus.pcsrc,
                bus.alucontrol};

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[64];
  int   n_tbl = 0;

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                     input logic zero, input word_t exp, input string name);
    tbl[n_tbl] = '{rst, op, funct, zero, exp, name};
    n_tbl++;
  endtask

  task automatic check(input word_t exp, input string name);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, compare mid-cycle, then advance past the edge.
  task automatic cycle(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                       input logic zero, input word_t exp, input string name);
    reset     = rst;
    bus.op    = op;
    bus.funct = funct;
    bus.zero  = zero;
    @(negedge clk);
    check(exp, name);
    @(posedge clk);
    #1;
  endtask

  // Reference model: instruction cycle count and per-cycle control word.
  function automatic int latency(input logic [5:0] op);
    case (op)
      6'b100011:                       return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010:            return 3;
      default:                         return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic word_t model(input logic [5:0] op, input logic [5:0] f,
                                  input logic z, input int k);
    word_t steps[5];
    steps[0] = W_FETCH;
    steps[1] = W_DECODE;
    steps[2] = W_FETCH;
    steps[3] = W_FETCH;
    steps[4] = W_FETCH;
    case (op)
      6'b100011: begin steps[2] = W_MEMADR; steps[3] = W_MEMRD; steps[4] = W_MEMWB; end
      6'b101011: begin steps[2] = W_MEMADR; steps[3] = W_MEMWR; end
      6'b000000: begin steps[2] = w_exec(funct_alu(f)); steps[3] = W_ALUWB; end
      6'b001000: begin steps[2] = W_ADDIEX; steps[3] = W_ADDIWB; end
      6'b000100: steps[2] = z ? W_BR_Z1 : W_BR_Z0;
      6'b000010: steps[2] = W_JUMP;
      default: ;
    endcase
    return steps[k];
  endfunction

  initial begin
    reset     = 1'b1;
    bus.op    = 6'b0;
    bus.funct = 6'b0;
    bus.zero  = 1'b0;

    // Two reset cycles: FETCH values with all writes masked.
    @(posedge clk); #1;
    @(negedge clk); check(W_RESET, "reset_c1");
    @(posedge clk); #1;
    @(negedge clk); check(W_RESET, "reset_c2");
    @(posedge clk); #1;

    // lw
    add(0, 6'b100011, 6'h00, 0, W_FETCH,  "lw_fetch");
    add(0, 6'b100011, 6'h00, 0, W_DECODE, "lw_decode");
    add(0, 6'b100011, 6'h00, 0, W_MEMADR, "lw_memadr");
    add(0, 6'b100011, 6'h00, 0, W_MEMRD,  "lw_memrd");
    add(0, 6'b100011, 6'h00, 0, W_MEMWB,  "lw_memwb");
    // R-type slt
    add(0, 6'b000000, 6'b101010, 0, W_FETCH,        "slt_fetch");
    add(0, 6'b000000, 6'b101010, 0, W_DECODE,       "slt_decode");
    add(0, 6'b000000, 6'b101010, 0, w_exec(3'b111), "slt_execute");
    add(0, 6'b000000, 6'b101010, 0, W_ALUWB,        "slt_aluwb");
    // beq taken / not taken
    add(0, 6'b000100, 6'h00, 1, W_FETCH,  "beq1_fetch");
    add(0, 6'b000100, 6'h00, 1, W_DECODE, "beq1_decode");
    add(0, 6'b000100, 6'h00, 1, W_BR_Z1,  "beq1_branch");
    add(0, 6'b000100, 6'h00, 0, W_FETCH,  "beq0_fetch");
    add(0, 6'b000100, 6'h00, 0, W_DECODE, "beq0_decode");
    add(0, 6'b000100, 6'h00, 0, W_BR_Z0,  "beq0_branch");
    // undefined opcode
    add(0, 6'b111111, 6'h00, 0, W_FETCH,  "bad_fetch");
    add(0, 6'b111111, 6'h00, 0, W_DECODE, "bad_decode");
    // sw aborted by reset in MEMWR, then re-run to completion
    add(0, 6'b101011, 6'h00, 0, W_FETCH,  "sw_fetch");
    add(0, 6'b101011, 6'h00, 0, W_DECODE, "sw_decode");
    add(0, 6'b101011, 6'h00, 0, W_MEMADR, "sw_memadr");
    add(1, 6'b101011, 6'h00, 0, W_RESET,  "sw_memwr_reset");
    add(0, 6'b101011, 6'h00, 0, W_FETCH,  "sw_refetch");
    add(0, 6'b101011, 6'h00, 0, W_DECODE, "sw2_decode");
    add(0, 6'b101011, 6'h00, 0, W_MEMADR, "sw2_memadr");
    add(0, 6'b101011, 6'h00, 0, W_MEMWR,  "sw2_memwr");
    // addi, j, R-type with unknown funct
    add(0, 6'b001000, 6'h00, 0, W_FETCH,  "addi_fetch");
    add(0, 6'b001000, 6'h00, 0, W_DECODE, "addi_decode");
    add(0, 6'b001000, 6'h00, 0, W_ADDIEX, "addi_ex");
    add(0, 6'b001000, 6'h00, 0, W_ADDIWB, "addi_wb");
    add(0, 6'b000010, 6'h00, 1, W_FETCH,  "j_fetch");
    add(0, 6'b000010, 6'h00, 1, W_DECODE, "j_decode");
    add(0, 6'b000010, 6'h00, 1, W_JUMP,   "j_jump");
    add(0, 6'b000000, 6'b000111, 0, W_FETCH,        "rx_fetch");
    add(0, 6'b000000, 6'b000111, 0, W_DECODE,       "rx_decode");
    add(0, 6'b000000, 6'b000111, 0, w_exec(3'b010), "rx_execute");
    add(0, 6'b000000, 6'b000111, 0, W_ALUWB,        "rx_aluwb");

    for (int i = 0; i < n_tbl; i++)
      cycle(tbl[i].rst, tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].exp, tbl[i].name);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      logic [5:0] f;
      int sel;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      case (int'($urandom_range(0, 5)))
        0: f = 6'b100000;
        1: f = 6'b100010;
        2: f = 6'b100100;
        3: f = 6'b100101;
        4: f = 6'b101010;
        default: f = 6'($urandom);
      endcase
      for (int k = 0; k < latency(op); k++) begin
        logic z;
        z = 1'($urandom_range(0, 1));
        cycle(1'b0, op, f, z, model(op, f, z, k), "random");
      end
    end

    // Reset held through ALUWB of an R-type: writes masked, FETCH held.
    cycle(0, 6'b000000, 6'b100010, 0, W_FETCH,        "rrst_fetch");
    cycle(0, 6'b000000, 6'b100010, 0, W_DECODE,       "rrst_decode");
    cycle(0, 6'b000000, 6'b100010, 0, w_exec(3'b110), "rrst_execute");
    cycle(1, 6'b000000, 6'b100010, 0, W_RESET,        "rrst_aluwb_reset");
    cycle(1, 6'b000000, 6'b100010, 1, W_RESET,        "rrst_hold");
    cycle(0, 6'b000000, 6'b100010, 0, W_FETCH,        "rrst_release");
    cycle(0, 6'b000000, 6'b100010, 0, W_DECODE,       "rrst_decode2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: op  input  6  instr[31:26]; funct  input  6  instr[5:0]; zero  input  1  ALU zero flag.
REQ-004 SHALL have outputs, 1 bit each: iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen.
- iord: memory address select.
- irwrite: instruction register write.
- memwrite / regwrite: memory / register-file write.
- regdst / memtoreg: write-register / write-data select.
- alusrca: ALU A select, 0 = PC, 1 = A register.
- pcen: PC write enable.
REQ-005 SHALL have outputs: alusrcb  output  2  ALU B select, 00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2; pcsrc  output  2  00 = aluresult, 01 = aluout, 10 = jump target; alucontrol  output  3  ALU operation code.

Function
REQ-006 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-007 SHALL transition as follows:
- FETCH -> DECODE.
- DECODE by op: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other op -> FETCH.
REQ-008 SHALL transition onward as follows:
- MEMADR -> MEMRD if op = 100011, else MEMWR.
- MEMRD -> MEMWB.
- EXECUTE -> ALUWB.
- ADDIEX -> ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
REQ-009 SHALL drive per state; every unlisted 1-bit control is 0, unlisted 2-bit control is 00, aluop defaults to 00.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: regwrite=1, memtoreg=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regwrite=1, regdst=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-010 SHALL compute pcen = pcwrite | (branch & zero) combinationally; zero is sampled in the BRANCH state only.
REQ-011 SHALL decode alucontrol from the internal 2-bit aluop:
- aluop 00 -> 010 (add).
- aluop 01 -> 110 (sub).
- aluop 10 by funct: 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111; any other funct -> 010.
- aluop 11 -> 010.
REQ-012 SHALL have a fixed latency of 3 cycles for beq and j, 4 cycles for R-type, addi and sw, and 5 cycles for lw; an undefined op SHALL consume 2 cycles with no write.
REQ-013 SHALL produce all outputs combinationally from state, op and funct, with no additional register stage.

Reset
REQ-014 SHALL load FETCH on the first rising clk edge with reset=1, and SHALL hold FETCH while reset stays high.
REQ-015 SHALL force irwrite, pcen, regwrite and memwrite to 0 while reset=1; all other outputs SHALL take their FETCH values (alusrcb=01, alucontrol=010).
REQ-016 SHALL abandon any in-flight instruction when reset is asserted mid-sequence, with no further write asserted.

Structure
REQ-017 SHALL place the state enum, opcode constants (LW, SW, RTYPE, BEQ, ADDI, J), funct constants and aluop encodings in a shared package, mips_ctrl_pkg.
REQ-018 SHALL split the design into the FSM plus one sub-module, aludec (inputs funct and aluop, output alucontrol).

Verification
REQ-019 SHALL cover: reset=1 for 2 cycles, then release -> state FETCH, irwrite=1, pcen=1, alusrcb=01 in the first cycle after release.
REQ-020 SHALL cover: lw (op=100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-021 SHALL cover: R-type op=000000 with funct=101010 -> EXECUTE with alucontrol=111, then ALUWB with regdst=1.
REQ-022 SHALL cover: beq with zero=1 -> pcen=1 and pcsrc=01 in BRANCH; repeat with zero=0 -> pcen=0.
REQ-023 SHALL cover: op=111111 -> DECODE returns to FETCH, with no regwrite or memwrite in any cycle.
REQ-024 SHALL cover: reset asserted during MEMWR of sw -> memwrite=0 in that cycle, and state FETCH on the next edge.
